// File: rtl/u_d_seq_counter.sv
// Up/down modulo-MOD sequence counter with load, binary/Gray output coding and wrap pulse.
// idx/wrap update one edge after sampling; out/tc are combinational from idx. No backpressure.
// Optional saturation (input sat) when compiled with U_D_SEQ_SAT_EN.
module u_d_seq_counter #(
  parameter int WIDTH = 3,
  parameter int MOD   = 8,
  parameter int START = 0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic             u,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             mode,
`ifdef U_D_SEQ_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] FIRST = WIDTH'(START);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             at_top;
  logic             at_bot;
  logic             hold_at_end;
  logic [WIDTH-1:0] idx_nxt;
  logic             wrap_nxt;

  assign at_top = (idx == LAST);
  assign at_bot = (idx == '0);

`ifdef U_D_SEQ_SAT_EN
  assign hold_at_end = sat;
`else
  assign hold_at_end = 1'b0;
`endif

  always_comb begin
    idx_nxt  = idx;
    wrap_nxt = 1'b0;
    if (ld) begin
      // out-of-range loads clamp to the terminal index so idx never leaves 0..MOD-1
      idx_nxt = (ld_val > LAST) ? LAST : ld_val;
    end else if (en) begin
      if (u) begin
        if (!at_top) begin
          idx_nxt = idx + ONE;
        end else if (!hold_at_end) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          idx_nxt = idx - ONE;
        end else if (!hold_at_end) begin
          idx_nxt  = LAST;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      idx  <= FIRST;
      wrap <= 1'b0;
    end else begin
      idx  <= idx_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign out = mode ? (idx ^ (idx >> 1)) : idx;
  assign tc  = u ? at_top : at_bot;

endmodule

// File: tb/tb_u_d_seq_counter.sv
// Bench for u_d_seq_counter: directed scenarios plus random traffic against a modulo-arithmetic model.
module tb_u_d_seq_counter;

  localparam int W     = 3;
  localparam int MOD   = 6;
  localparam int START = 2;

  logic         clk = 1'b0;
  logic         r, en, u, ld, mode;
  logic [W-1:0] ld_val;
  logic [W-1:0] idx, out;
  logic         tc, wrap;
`ifdef U_D_SEQ_SAT_EN
  logic         sat;
  logic         g_sat;
`endif

  logic         g_r, g_en, g_u, g_ld, g_mode;
  logic [3:0]   g_ld_val, g_idx, g_out;
  logic         g_tc, g_wrap;

  int vectors    = 0;
  int miscompares = 0;

  int m_idx;
  int m_wrap;

  always #5 clk = ~clk;

  u_d_seq_counter #(.WIDTH(W), .MOD(MOD), .START(START)) dut (
    .clk(clk), .r(r), .en(en), .u(u), .ld(ld), .ld_val(ld_val), .mode(mode),
`ifdef U_D_SEQ_SAT_EN
    .sat(sat),
`endif
    .idx(idx), .out(out), .tc(tc), .wrap(wrap)
  );

  u_d_seq_counter #(.WIDTH(4), .MOD(16), .START(0)) dut_g (
    .clk(clk), .r(g_r), .en(g_en), .u(g_u), .ld(g_ld), .ld_val(g_ld_val), .mode(g_mode),
`ifdef U_D_SEQ_SAT_EN
    .sat(g_sat),
`endif
    .idx(g_idx), .out(g_out), .tc(g_tc), .wrap(g_wrap)
  );

  function automatic logic [W-1:0] exp_out(input int i, input logic md);
    logic [W-1:0] b;
    b = W'(i);
    return md ? (b ^ (b >> 1)) : b;
  endfunction

  function automatic logic exp_tc(input int i, input logic dir);
    return dir ? (i == MOD - 1) : (i == 0);
  endfunction

  // Apply one edge and advance the reference model by the counting rules.
  task automatic drive(input logic rr, input logic ll, input logic ee, input logic uu,
                       input logic md, input int lv, input logic st);
    int  nxt;
    bit  crossed;
    bit  sat_on;
    r = rr; ld = ll; en = ee; u = uu; mode = md; ld_val = W'(lv);
`ifdef U_D_SEQ_SAT_EN
    sat = st;
    sat_on = st;
`else
    sat_on = 1'b0;
`endif
    @(posedge clk);
    if (rr) begin
      m_idx = START; m_wrap = 0;
    end else if (ll) begin
      m_idx = (lv < MOD) ? lv : MOD - 1; m_wrap = 0;
    end else if (ee) begin
      nxt     = uu ? (m_idx + 1) % MOD : (m_idx + MOD - 1) % MOD;
      crossed = uu ? (nxt < m_idx) : (nxt > m_idx);
      if (crossed && sat_on) m_wrap = 0;
      else begin m_idx = nxt; m_wrap = crossed; end
    end else begin
      m_wrap = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 0, 5, 0);
    vectors++;
    if (idx !== W'(START) || wrap !== 1'b0 || out !== W'(START) || tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: idx=%0d wrap=%b out=%b tc=%b, want idx=%0d wrap=0 out=%b tc=0",
               idx, wrap, out, tc, START, W'(START));
    end
  endtask

  task automatic test_up_seq();
    int want[5] = '{3, 4, 5, 0, 1};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0, 0, 0);
      vectors++;
      if (idx !== W'(want[i]) || wrap !== (want[i] == 0) || tc !== (want[i] == MOD - 1)
          || out !== exp_out(want[i], 1'b0)) begin
        miscompares++;
        $display("FAIL up_seq step %0d: idx=%0d wrap=%b tc=%b out=%b, want idx=%0d wrap=%b tc=%b",
                 i, idx, wrap, tc, out, want[i], want[i] == 0, want[i] == MOD - 1);
      end
    end
  endtask

  task automatic test_down_seq();
    int want[3] = '{0, 5, 4};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      vectors++;
      if (idx !== W'(want[i]) || wrap !== (want[i] == 5) || tc !== (want[i] == 0)) begin
        miscompares++;
        $display("FAIL down_seq step %0d: idx=%0d wrap=%b tc=%b, want idx=%0d wrap=%b tc=%b",
                 i, idx, wrap, tc, want[i], want[i] == 5, want[i] == 0);
      end
    end
  endtask

  task automatic test_load();
    drive(0, 1, 1, 1, 0, 7, 0);
    vectors++;
    if (idx !== 3'd5 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL load_clamp: idx=%0d wrap=%b, want idx=5 wrap=0", idx, wrap);
    end
    drive(1, 1, 0, 0, 0, 3, 0);
    vectors++;
    if (idx !== 3'd2 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL load_vs_reset: idx=%0d wrap=%b, want idx=2 wrap=0", idx, wrap);
    end
  endtask

  task automatic test_mode();
    drive(0, 1, 0, 0, 0, 5, 0);
    vectors++;
    if (out !== 3'b101) begin
      miscompares++;
      $display("FAIL mode_bin: out=%b, want 101", out);
    end
    mode = 1'b1;
    #1;
    vectors++;
    if (out !== 3'b111 || idx !== 3'd5) begin
      miscompares++;
      $display("FAIL mode_gray: out=%b idx=%0d, want out=111 idx=5", out, idx);
    end
    mode = 1'b0;
  endtask

`ifdef U_D_SEQ_SAT_EN
  task automatic test_sat();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 1);
      vectors++;
      if (idx !== 3'd5 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_hold step %0d: idx=%0d wrap=%b, want idx=5 wrap=0", i, idx, wrap);
      end
    end
    drive(0, 0, 1, 1, 0, 0, 0);
    vectors++;
    if (idx !== 3'd0 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_release: idx=%0d wrap=%b, want idx=0 wrap=1", idx, wrap);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      vectors++;
      if (idx !== W'(m_idx) || wrap !== 1'(m_wrap) || tc !== exp_tc(m_idx, u)
          || out !== exp_out(m_idx, mode)) begin
        miscompares++;
        $display("FAIL random %0d: idx=%0d wrap=%b tc=%b out=%b, want idx=%0d wrap=%0d tc=%b out=%b",
                 i, idx, wrap, tc, out, m_idx, m_wrap, exp_tc(m_idx, u), exp_out(m_idx, mode));
      end
    end
  endtask

  task automatic test_gray16();
    logic [3:0] prev;
    logic [3:0] want;
    g_r = 1'b1; g_en = 1'b0; g_u = 1'b1; g_ld = 1'b0; g_mode = 1'b1; g_ld_val = '0;
    @(posedge clk); #1;
    g_r = 1'b0; g_en = 1'b1;
    prev = g_out;
    vectors++;
    if (g_out !== 4'b0000) begin
      miscompares++;
      $display("FAIL gray16_reset: out=%b, want 0000", g_out);
    end
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      want = 4'(i % 16);
      want = want ^ (want >> 1);
      vectors++;
      if ($countones(g_out ^ prev) != 1 || g_out !== want || g_wrap !== (i == 16)) begin
        miscompares++;
        $display("FAIL gray16 step %0d: out=%b prev=%b wrap=%b, want out=%b wrap=%b",
                 i, g_out, prev, g_wrap, want, i == 16);
      end
      prev = g_out;
    end
    g_en = 1'b0;
  endtask

  initial begin
    r = 1'b1; en = 1'b0; u = 1'b0; ld = 1'b0; mode = 1'b0; ld_val = '0;
`ifdef U_D_SEQ_SAT_EN
    sat = 1'b0; g_sat = 1'b0;
`endif
    g_r = 1'b1; g_en = 1'b0; g_u = 1'b1; g_ld = 1'b0; g_mode = 1'b0; g_ld_val = '0;
    m_idx = START; m_wrap = 0;
    #1;
    test_reset();
    test_up_seq();
    test_down_seq();
    test_load();
    test_mode();
`ifdef U_D_SEQ_SAT_EN
    test_sat();
`endif
    test_random();
    test_gray16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
